otbn_cmd_ctrl: RTL and testbench

Command sequencer sitting between the OTBN register interface and the OTBN core/memories. It accepts CMD writes, issues a one-cycle start to the core, runs secure-wipe sweeps over DMEM/IMEM, and tracks STATUS. On completion it captures ERR_BITS and INSN_CNT, pulses a done interrupt, and locks permanently on fatal errors or escalation.

---
 rtl/otbn_cmd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_otbn_cmd_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otbn_cmd_ctrl.sv
// OTBN command sequencer: accepts CMD writes, starts the core, sweeps DMEM/IMEM
// during secure wipe, tracks STATUS and locks permanently on fatal errors.
module otbn_cmd_ctrl #(
    parameter int          ImemSizeByte  = 4096,
    parameter int          DmemSizeByte  = 4096,
    parameter logic [7:0]  FatalErrMask  = 8'hF0,
    localparam int ImemAddrWidth = (ImemSizeByte > 1) ? $clog2(ImemSizeByte) : 1,
    localparam int ImemWipeWords = ImemSizeByte / 4,
    localparam int DmemWipeWords = DmemSizeByte / 32,
    localparam int WipeMaxWords  = (ImemWipeWords > DmemWipeWords) ? ImemWipeWords : DmemWipeWords,
    localparam int WipeIdxW      = (WipeMaxWords > 1) ? $clog2(WipeMaxWords) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cmd_we_i,
    input  logic [7:0]               cmd_i,
    input  logic [ImemAddrWidth-1:0] start_addr_i,
    input  logic                     escalate_i,
    input  logic                     core_done_i,
    input  logic [7:0]               core_err_bits_i,
    input  logic [31:0]              core_insn_cnt_i,
    output logic                     start_o,
    output logic [ImemAddrWidth-1:0] start_addr_o,
    output logic                     dmem_wipe_o,
    output logic                     imem_wipe_o,
    output logic [WipeIdxW-1:0]      wipe_idx_o,
    output logic [7:0]               status_o,
    output logic [7:0]               err_bits_o,
    output logic [31:0]              insn_cnt_o,
    output logic                     done_o,
    output logic                     cmd_rejected_o
);

    // State encodings double as the STATUS register value.
    typedef enum logic [7:0] {
        StIdle          = 8'h00,
        StBusyExecute   = 8'h01,
        StBusyWipeDmem  = 8'h02,
        StBusyWipeImem  = 8'h03,
        StLocked        = 8'hFF
    } state_e;

    localparam logic [7:0] CmdExecute  = 8'hD8;
    localparam logic [7:0] CmdWipeDmem = 8'hC3;
    localparam logic [7:0] CmdWipeImem = 8'h1E;

    localparam logic [WipeIdxW-1:0] DmemLastIdx = WipeIdxW'(DmemWipeWords - 1);
    localparam logic [WipeIdxW-1:0] ImemLastIdx = WipeIdxW'(ImemWipeWords - 1);

    state_e                     r_state;
    logic [WipeIdxW-1:0]        r_wipe_cnt;
    logic                       r_start;
    logic [ImemAddrWidth-1:0]   r_start_addr;
    logic [7:0]                 r_err_bits;
    logic [31:0]                r_insn_cnt;
    logic                       r_done;
    logic                       r_cmd_rej;

    state_e                     w_next_state;
    logic [WipeIdxW-1:0]        w_cnt_next;
    logic                       w_start_next;
    logic                       w_done_next;
    logic                       w_rej_next;
    logic                       w_latch_addr;
    logic                       w_clear_result;
    logic                       w_latch_core;
    logic                       w_wipe_last;
    logic                       w_dmem_strobe;
    logic                       w_imem_strobe;

    assign w_dmem_strobe = (r_state == StBusyWipeDmem);
    assign w_imem_strobe = (r_state == StBusyWipeImem);
    assign w_wipe_last   = w_dmem_strobe ? (r_wipe_cnt == DmemLastIdx)
                                         : (r_wipe_cnt == ImemLastIdx);

    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = r_wipe_cnt;
        w_start_next   = 1'b0;
        w_done_next    = 1'b0;
        w_rej_next     = 1'b0;
        w_latch_addr   = 1'b0;
        w_clear_result = 1'b0;
        w_latch_core   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (escalate_i) begin
                    w_next_state = StLocked;
                    w_rej_next   = cmd_we_i;
                end else if (cmd_we_i) begin
                    unique case (cmd_i)
                        CmdExecute: begin
                            w_next_state   = StBusyExecute;
                            w_start_next   = 1'b1;
                            w_latch_addr   = 1'b1;
                            w_clear_result = 1'b1;
                        end
                        CmdWipeDmem: begin
                            w_next_state = StBusyWipeDmem;
                            w_cnt_next   = '0;
                        end
                        CmdWipeImem: begin
                            w_next_state = StBusyWipeImem;
                            w_cnt_next   = '0;
                        end
                        default: w_rej_next = 1'b1;
                    endcase
                end
            end
            StBusyExecute: begin
                w_rej_next = cmd_we_i;
                // Core results latch even when escalation forces the lock.
                if (core_done_i) begin
                    w_latch_core = 1'b1;
                    w_done_next  = 1'b1;
                    w_next_state = (escalate_i || ((core_err_bits_i & FatalErrMask) != 8'h00))
                                   ? StLocked : StIdle;
                end else if (escalate_i) begin
                    w_done_next  = 1'b1;
                    w_next_state = StLocked;
                end
            end
            StBusyWipeDmem, StBusyWipeImem: begin
                w_rej_next = cmd_we_i;
                if (escalate_i) begin
                    w_done_next  = 1'b1;
                    w_next_state = StLocked;
                    w_cnt_next   = '0;
                end else if (w_wipe_last) begin
                    w_done_next  = 1'b1;
                    w_next_state = StIdle;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_wipe_cnt + WipeIdxW'(1);
                end
            end
            default: begin
                w_rej_next = cmd_we_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_wipe_cnt   <= '0;
            r_start      <= 1'b0;
            r_start_addr <= '0;
            r_err_bits   <= 8'h00;
            r_insn_cnt   <= 32'h0;
            r_done       <= 1'b0;
            r_cmd_rej    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wipe_cnt <= w_cnt_next;
            r_start    <= w_start_next;
            r_done     <= w_done_next;
            r_cmd_rej  <= w_rej_next;
            if (w_latch_addr) begin
                r_start_addr <= start_addr_i;
            end
            if (w_clear_result) begin
                r_err_bits <= 8'h00;
                r_insn_cnt <= 32'h0;
            end else if (w_latch_core) begin
                r_err_bits <= core_err_bits_i;
                r_insn_cnt <= core_insn_cnt_i;
            end
        end
    end

    assign start_o        = r_start;
    assign start_addr_o   = r_start_addr;
    assign dmem_wipe_o    = w_dmem_strobe;
    assign imem_wipe_o    = w_imem_strobe;
    assign wipe_idx_o     = (w_dmem_strobe || w_imem_strobe) ? r_wipe_cnt : '0;
    assign status_o       = r_state;
    assign err_bits_o     = r_err_bits;
    assign insn_cnt_o     = r_insn_cnt;
    assign done_o         = r_done;
    assign cmd_rejected_o = r_cmd_rej;

endmodule

// File: tb/tb_otbn_cmd_ctrl.sv
// Self-checking bench for otbn_cmd_ctrl: scenario tasks with a scoreboard of
// expected wipe indices and execute completions.
module tb_otbn_cmd_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_we_i;
    logic [7:0]  cmd_i;
    logic [11:0] start_addr_i;
    logic        escalate_i;
    logic        core_done_i;
    logic [7:0]  core_err_bits_i;
    logic [31:0] core_insn_cnt_i;

    logic        start_o;
    logic [11:0] start_addr_o;
    logic        dmem_wipe_o;
    logic        imem_wipe_o;
    logic [9:0]  wipe_idx_o;
    logic [7:0]  status_o;
    logic [7:0]  err_bits_o;
    logic [31:0] insn_cnt_o;
    logic        done_o;
    logic        cmd_rejected_o;

    typedef struct packed {
        logic [7:0]  status;
        logic [7:0]  errBits;
        logic [31:0] insnCnt;
    } doneExp_t;

    doneExp_t doneQ[$];
    int       wipeQ[$];
    int       checkCount = 0;
    int       passCount  = 0;

    otbn_cmd_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cmd_we_i        (cmd_we_i),
        .cmd_i           (cmd_i),
        .start_addr_i    (start_addr_i),
        .escalate_i      (escalate_i),
        .core_done_i     (core_done_i),
        .core_err_bits_i (core_err_bits_i),
        .core_insn_cnt_i (core_insn_cnt_i),
        .start_o         (start_o),
        .start_addr_o    (start_addr_o),
        .dmem_wipe_o     (dmem_wipe_o),
        .imem_wipe_o     (imem_wipe_o),
        .wipe_idx_o      (wipe_idx_o),
        .status_o        (status_o),
        .err_bits_o      (err_bits_o),
        .insn_cnt_o      (insn_cnt_o),
        .done_o          (done_o),
        .cmd_rejected_o  (cmd_rejected_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance past the next rising edge; outputs then reflect that edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cmd_we_i = 1'b0; cmd_i = 8'h00; start_addr_i = '0;
        escalate_i = 1'b0; core_done_i = 1'b0; core_err_bits_i = 8'h00; core_insn_cnt_i = 32'h0;
        step(); step();
        checkCount++;
        if ({start_o, dmem_wipe_o, imem_wipe_o, done_o, cmd_rejected_o} !== 5'b0)
            $display("[TB] FAIL reset_pulses: got %b expected 00000",
                     {start_o, dmem_wipe_o, imem_wipe_o, done_o, cmd_rejected_o});
        else passCount++;
        checkCount++;
        if ({status_o, err_bits_o, insn_cnt_o, start_addr_o, wipe_idx_o} !== 70'h0)
            $display("[TB] FAIL reset_regs: status %h err %h cnt %h addr %h idx %h expected all 0",
                     status_o, err_bits_o, insn_cnt_o, start_addr_o, wipe_idx_o);
        else passCount++;
        rst_i = 1'b0;
        step();
    endtask

    task automatic issueExecute(input logic [11:0] addr);
        cmd_we_i = 1'b1; cmd_i = 8'hD8; start_addr_i = addr;
        step();
        cmd_we_i = 1'b0; start_addr_i = 12'hFFF;
        checkCount++;
        if (start_o !== 1'b1) $display("[TB] FAIL exec_start: got %b expected 1", start_o);
        else passCount++;
        checkCount++;
        if (status_o !== 8'h01) $display("[TB] FAIL exec_status: got %h expected 01", status_o);
        else passCount++;
        checkCount++;
        if (start_addr_o !== addr) $display("[TB] FAIL exec_addr: got %h expected %h", start_addr_o, addr);
        else passCount++;
        checkCount++;
        if ({err_bits_o, insn_cnt_o} !== 40'h0)
            $display("[TB] FAIL exec_clear: err %h cnt %h expected 0", err_bits_o, insn_cnt_o);
        else passCount++;
        step();
        checkCount++;
        if (start_o !== 1'b0 || status_o !== 8'h01)
            $display("[TB] FAIL exec_start_once: start %b status %h expected 0/01", start_o, status_o);
        else passCount++;
    endtask

    task automatic finishExecute(input logic [7:0] err, input logic [31:0] cnt, input logic [7:0] expStatus);
        doneExp_t exp;
        core_done_i = 1'b1; core_err_bits_i = err; core_insn_cnt_i = cnt;
        doneQ.push_back('{status: expStatus, errBits: err, insnCnt: cnt});
        step();
        core_done_i = 1'b0; core_err_bits_i = 8'hAA; core_insn_cnt_i = 32'hDEAD_BEEF;
        exp = doneQ.pop_front();
        checkCount++;
        if (status_o !== exp.status) $display("[TB] FAIL done_status: got %h expected %h", status_o, exp.status);
        else passCount++;
        checkCount++;
        if (err_bits_o !== exp.errBits) $display("[TB] FAIL done_err: got %h expected %h", err_bits_o, exp.errBits);
        else passCount++;
        checkCount++;
        if (insn_cnt_o !== exp.insnCnt) $display("[TB] FAIL done_cnt: got %h expected %h", insn_cnt_o, exp.insnCnt);
        else passCount++;
        checkCount++;
        if (done_o !== 1'b1) $display("[TB] FAIL done_pulse: got %b expected 1", done_o);
        else passCount++;
        step();
        checkCount++;
        if (done_o !== 1'b0) $display("[TB] FAIL done_once: got %b expected 0", done_o);
        else passCount++;
    endtask

    task automatic test_execute();
        issueExecute(12'h040);
        finishExecute(8'h00, 32'h1234, 8'h00);
    endtask

    task automatic test_recoverable();
        issueExecute(12'h080);
        finishExecute(8'h01, 32'h0000_0007, 8'h00);
        issueExecute(12'h084);
        finishExecute(8'h00, 32'h0000_0003, 8'h00);
    endtask

    task automatic test_rejected();
        issueExecute(12'h010);
        cmd_we_i = 1'b1; cmd_i = 8'hD8; start_addr_i = 12'h7FC;
        step();
        cmd_we_i = 1'b0;
        checkCount++;
        if (cmd_rejected_o !== 1'b1 || start_o !== 1'b0)
            $display("[TB] FAIL rej_busy: rej %b start %b expected 1/0", cmd_rejected_o, start_o);
        else passCount++;
        checkCount++;
        if (status_o !== 8'h01 || start_addr_o !== 12'h010)
            $display("[TB] FAIL rej_busy_state: status %h addr %h expected 01/010", status_o, start_addr_o);
        else passCount++;
        step();
        checkCount++;
        if (cmd_rejected_o !== 1'b0) $display("[TB] FAIL rej_busy_once: got %b expected 0", cmd_rejected_o);
        else passCount++;
        finishExecute(8'h00, 32'h0000_0009, 8'h00);
        cmd_we_i = 1'b1; cmd_i = 8'h55;
        step();
        cmd_we_i = 1'b0;
        checkCount++;
        if (cmd_rejected_o !== 1'b1 || status_o !== 8'h00 || start_o !== 1'b0)
            $display("[TB] FAIL rej_unknown: rej %b status %h start %b expected 1/00/0",
                     cmd_rejected_o, status_o, start_o);
        else passCount++;
        step();
        checkCount++;
        if (cmd_rejected_o !== 1'b0 || status_o !== 8'h00)
            $display("[TB] FAIL rej_unknown_once: rej %b status %h expected 0/00", cmd_rejected_o, status_o);
        else passCount++;
    endtask

    task automatic test_dmem_wipe();
        int  cyc;
        int  strobes;
        bit  imemSeen;
        cmd_we_i = 1'b1; cmd_i = 8'hC3;
        for (int i = 0; i < 128; i++) wipeQ.push_back(i);
        step();
        cmd_we_i = 1'b0;
        cyc = 1; strobes = 0; imemSeen = 1'b0;
        while (dmem_wipe_o === 1'b1 && cyc < 200) begin
            if (imem_wipe_o !== 1'b0) imemSeen = 1'b1;
            checkCount++;
            if (wipeQ.size() == 0) begin
                $display("[TB] FAIL dmem_extra_strobe: idx %0d expected no strobe", wipe_idx_o);
            end else begin
                int expIdx;
                expIdx = wipeQ.pop_front();
                if (int'(wipe_idx_o) !== expIdx)
                    $display("[TB] FAIL dmem_idx: got %0d expected %0d", wipe_idx_o, expIdx);
                else passCount++;
            end
            strobes++;
            step();
            cyc++;
        end
        checkCount++;
        if (strobes !== 128 || wipeQ.size() !== 0)
            $display("[TB] FAIL dmem_count: got %0d strobes expected 128", strobes);
        else passCount++;
        wipeQ.delete();
        checkCount++;
        if (imemSeen) $display("[TB] FAIL dmem_no_imem: got imem strobe expected none");
        else passCount++;
        checkCount++;
        if (cyc !== 129 || status_o !== 8'h00 || done_o !== 1'b1 || wipe_idx_o !== 10'd0)
            $display("[TB] FAIL dmem_end: cycle %0d status %h done %b idx %0d expected 129/00/1/0",
                     cyc, status_o, done_o, wipe_idx_o);
        else passCount++;
        step();
        checkCount++;
        if (done_o !== 1'b0) $display("[TB] FAIL dmem_done_once: got %b expected 0", done_o);
        else passCount++;
    endtask

    task automatic test_escalate_reset();
        int cyc;
        int doneCount;
        cmd_we_i = 1'b1; cmd_i = 8'h1E;
        for (int i = 0; i <= 10; i++) wipeQ.push_back(i);
        step();
        cmd_we_i = 1'b0;
        cyc = 0;
        while (wipeQ.size() > 0 && cyc < 50) begin
            int expIdx;
            expIdx = wipeQ.pop_front();
            checkCount++;
            if (imem_wipe_o !== 1'b1 || int'(wipe_idx_o) !== expIdx)
                $display("[TB] FAIL imem_idx: strobe %b idx %0d expected 1/%0d", imem_wipe_o, wipe_idx_o, expIdx);
            else passCount++;
            if (wipeQ.size() > 0) begin
                step();
                cyc++;
            end
        end
        if (cyc >= 50) begin
            checkCount++;
            $display("[TB] FAIL imem_timeout: got %0d cycles expected idx 10 within 50", cyc);
        end
        escalate_i = 1'b1;
        step();
        escalate_i = 1'b0;
        checkCount++;
        if (status_o !== 8'hFF || imem_wipe_o !== 1'b0 || wipe_idx_o !== 10'd0 || done_o !== 1'b1)
            $display("[TB] FAIL esc_lock: status %h strobe %b idx %0d done %b expected FF/0/0/1",
                     status_o, imem_wipe_o, wipe_idx_o, done_o);
        else passCount++;
        doneCount = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done_o === 1'b1 || imem_wipe_o === 1'b1 || status_o !== 8'hFF) doneCount++;
        end
        checkCount++;
        if (doneCount !== 0) $display("[TB] FAIL esc_stable: got %0d bad cycles expected 0", doneCount);
        else passCount++;
        rst_i = 1'b1;
        #1;
        checkCount++;
        if ({status_o, err_bits_o, insn_cnt_o, start_addr_o, start_o, done_o, cmd_rejected_o, imem_wipe_o} !== 64'h0)
            $display("[TB] FAIL async_reset: status %h err %h cnt %h addr %h expected all 0",
                     status_o, err_bits_o, insn_cnt_o, start_addr_o);
        else passCount++;
        step();
        rst_i = 1'b0;
        issueExecute(12'h0AC);
        finishExecute(8'h00, 32'h0000_0042, 8'h00);
    endtask

    task automatic test_fatal();
        issueExecute(12'h100);
        finishExecute(8'h20, 32'h0000_0055, 8'hFF);
        cmd_we_i = 1'b1; cmd_i = 8'hD8; start_addr_i = 12'h200;
        step();
        cmd_we_i = 1'b0;
        checkCount++;
        if (cmd_rejected_o !== 1'b1 || start_o !== 1'b0 || status_o !== 8'hFF)
            $display("[TB] FAIL locked_reject: rej %b start %b status %h expected 1/0/FF",
                     cmd_rejected_o, start_o, status_o);
        else passCount++;
        step();
        checkCount++;
        if (start_o !== 1'b0 || status_o !== 8'hFF || err_bits_o !== 8'h20)
            $display("[TB] FAIL locked_hold: start %b status %h err %h expected 0/FF/20",
                     start_o, status_o, err_bits_o);
        else passCount++;
    endtask

    initial begin
        test_reset();
        test_execute();
        test_recoverable();
        test_rejected();
        test_dmem_wipe();
        test_escalate_reset();
        test_fatal();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
